// File: rtl/cpu_wb_arbiter_if.sv
// Bus bundle between the writeback sources, the register bank write port and the forwarding unit.
// The arbiter connects through the slave modport. The producers and consumers connect through the master modport.
interface cpu_wb_arbiter_if #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned REG_ADDR  = 5
);
  logic                 wb_valid;
  logic [REG_ADDR-1:0]  wb_reg;
  logic [REG_WIDTH-1:0] wb_data;
  logic                 wb_ready;
  logic                 mul_valid;
  logic [REG_ADDR-1:0]  mul_reg;
  logic [REG_WIDTH-1:0] mul_data;
  logic                 mul_full;
  logic                 rf_we;
  logic [REG_ADDR-1:0]  rf_reg;
  logic [REG_WIDTH-1:0] rf_data;
  logic [REG_ADDR-1:0]  fw_reg;
  logic                 fw_hit;
  logic [REG_WIDTH-1:0] fw_data;
  logic                 ovf_err;

  modport slave (
    input  wb_valid, wb_reg, wb_data, mul_valid, mul_reg, mul_data, fw_reg,
    output wb_ready, mul_full, rf_we, rf_reg, rf_data, fw_hit, fw_data, ovf_err
  );

  modport master (
    output wb_valid, wb_reg, wb_data, mul_valid, mul_reg, mul_data, fw_reg,
    input  wb_ready, mul_full, rf_we, rf_reg, rf_data, fw_hit, fw_data, ovf_err
  );
endinterface

// File: rtl/cpu_wb_arbiter.sv
// Merges the stallable main-pipe writeback and the non-stallable multiplier stream onto one register-bank write port.
// Mul results wait in a small FIFO. A main write kills any pending mul result to the same register (WAW ordering).
module cpu_wb_arbiter #(
  parameter int unsigned REG_WIDTH    = 32,
  parameter int unsigned REG_ADDR     = 5,
  parameter int unsigned MUL_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic            clock,
  input logic            reset,
  cpu_wb_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(MUL_DEPTH);
  localparam int unsigned CNT_W = $clog2(MUL_DEPTH + 1);
  localparam int unsigned STW   = $clog2(STARVE_LIMIT + 1);

  logic [REG_WIDTH-1:0] r_data [MUL_DEPTH];
  logic [REG_ADDR-1:0]  r_reg  [MUL_DEPTH];
  logic [MUL_DEPTH-1:0] r_live;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [STW-1:0]       r_starve;
  logic                 r_ovf;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_head_live;
  logic                 w_head_dead;
  logic                 w_starve;
  logic                 w_wb_acc;
  logic                 w_drain;
  logic                 w_pop;
  logic                 w_enq;
  logic                 w_enq_live;
  logic                 w_ovf_set;
  logic [MUL_DEPTH-1:0] w_kill;
  logic                 w_fw_hit;
  logic [REG_WIDTH-1:0] w_fw_data;

  // Arbitration: a starved live head beats the main pipe, and the main pipe beats an unstarved head.
  always_comb begin
    w_empty     = (r_count == CNT_W'(0));
    w_full      = (r_count == CNT_W'(MUL_DEPTH));
    w_head_live = !w_empty && r_live[r_head];
    w_head_dead = !w_empty && !r_live[r_head];
    w_starve    = (r_starve >= STW'(STARVE_LIMIT)) && w_head_live;
    w_wb_acc    = bus.wb_valid && !w_starve;
    w_drain     = w_head_live && !w_wb_acc;
    w_pop       = w_drain || w_head_dead;
    w_enq       = bus.mul_valid && (!w_full || w_pop);
    w_ovf_set   = bus.mul_valid && w_full && !w_pop;
    w_enq_live  = !(w_wb_acc && (bus.wb_reg == bus.mul_reg));
    for (int i = 0; i < MUL_DEPTH; i++) begin
      w_kill[i] = w_wb_acc && (r_reg[i] == bus.wb_reg);
    end
  end

  // Forwarding lookup: walk from head to tail so the youngest live match wins.
  always_comb begin
    w_fw_hit  = 1'b0;
    w_fw_data = '0;
    for (int k = 0; k < MUL_DEPTH; k++) begin
      if ((CNT_W'(k) < r_count) && r_live[r_head + PTR_W'(k)] &&
          (r_reg[r_head + PTR_W'(k)] == bus.fw_reg)) begin
        w_fw_hit  = 1'b1;
        w_fw_data = r_data[r_head + PTR_W'(k)];
      end
    end
  end

  assign bus.wb_ready = reset ? 1'b1 : !w_starve;
  assign bus.rf_we    = !reset && (w_drain || w_wb_acc);
  assign bus.rf_reg   = w_drain ? r_reg[r_head]  : (w_wb_acc ? bus.wb_reg  : '0);
  assign bus.rf_data  = w_drain ? r_data[r_head] : (w_wb_acc ? bus.wb_data : '0);
  assign bus.fw_hit   = !reset && w_fw_hit;
  assign bus.fw_data  = w_fw_data;
  assign bus.mul_full = !reset && w_full;
  assign bus.ovf_err  = r_ovf;

  // Control state: pointers, count, live bits, starvation counter and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_live   <= '0;
      r_starve <= '0;
      r_ovf    <= 1'b0;
    end else begin
      for (int i = 0; i < MUL_DEPTH; i++) begin
        if (w_kill[i]) r_live[i] <= 1'b0;
      end
      if (w_enq) begin
        r_live[r_tail] <= w_enq_live;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_pop) r_head <= r_head + PTR_W'(1);
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_empty || w_drain) begin
        r_starve <= '0;
      end else if (w_head_live && (r_starve < STW'(STARVE_LIMIT))) begin
        r_starve <= r_starve + STW'(1);
      end
      if (w_ovf_set) r_ovf <= 1'b1;
    end
  end

  // Payload storage needs no reset; validity is carried by count and live bits.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_data[r_tail] <= bus.mul_data;
      r_reg[r_tail]  <= bus.mul_reg;
    end
  end
endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Directed bench for cpu_wb_arbiter: inputs change on the falling edge, and outputs are checked 1 ns later.
module tb_cpu_wb_arbiter;
  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  cpu_wb_arbiter_if #(.REG_WIDTH(32), .REG_ADDR(5)) bus ();

  cpu_wb_arbiter #(
    .REG_WIDTH(32), .REG_ADDR(5), .MUL_DEPTH(4), .STARVE_LIMIT(3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                     input logic mv, input logic [4:0] mr, input logic [31:0] md,
                     input logic [4:0] fr);
    @(negedge clock);
    bus.wb_valid  = wv;
    bus.wb_reg    = wr;
    bus.wb_data   = wd;
    bus.mul_valid = mv;
    bus.mul_reg   = mr;
    bus.mul_data  = md;
    bus.fw_reg    = fr;
    #1;
  endtask

  task automatic idle(input logic [4:0] fr);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, fr);
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] r, input logic [31:0] d);
    chk({tag, "_we"},   32'(bus.rf_we),   32'h1);
    chk({tag, "_reg"},  32'(bus.rf_reg),  32'(r));
    chk({tag, "_data"}, bus.rf_data,      d);
  endtask

  initial begin
    reset = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
    bus.mul_valid = 1'b0; bus.mul_reg = '0; bus.mul_data = '0; bus.fw_reg = '0;

    // Reset values while reset is held and after it is released.
    idle(5'd0);
    chk("rst_we",    32'(bus.rf_we),    32'h0);
    chk("rst_ready", 32'(bus.wb_ready), 32'h1);
    chk("rst_full",  32'(bus.mul_full), 32'h0);
    chk("rst_hit",   32'(bus.fw_hit),   32'h0);
    idle(5'd0);
    chk("rst_ovf",   32'(bus.ovf_err),  32'h0);
    reset = 1'b0;
    idle(5'd0);
    chk("post_we",    32'(bus.rf_we),    32'h0);
    chk("post_ready", 32'(bus.wb_ready), 32'h1);
    chk("post_full",  32'(bus.mul_full), 32'h0);

    // Test 1: a lone mul result is written on the following cycle.
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h11, 5'd3);
    chk("t1_pre_hit", 32'(bus.fw_hit), 32'h0);
    chk("t1_pre_we",  32'(bus.rf_we),  32'h0);
    idle(5'd3);
    chk_wr("t1_drain", 5'd3, 32'h11);
    chk("t1_drain_hit", 32'(bus.fw_hit), 32'h1);
    chk("t1_drain_fwd", bus.fw_data,     32'h11);
    idle(5'd3);
    chk("t1_after_we",  32'(bus.rf_we),  32'h0);
    chk("t1_after_hit", 32'(bus.fw_hit), 32'h0);

    // Test 2: the main pipe holds off the mul head for three cycles, then stalls for one cycle.
    cyc(1'b1, 5'd1, 32'hA0, 1'b1, 5'd4, 32'h55, 5'd0);
    chk_wr("t2_c0", 5'd1, 32'hA0);
    cyc(1'b1, 5'd1, 32'hA1, 1'b0, 5'd0, 32'h0, 5'd0);
    chk_wr("t2_c1", 5'd1, 32'hA1);
    cyc(1'b1, 5'd1, 32'hA2, 1'b0, 5'd0, 32'h0, 5'd0);
    chk_wr("t2_c2", 5'd1, 32'hA2);
    cyc(1'b1, 5'd1, 32'hA3, 1'b0, 5'd0, 32'h0, 5'd0);
    chk_wr("t2_c3", 5'd1, 32'hA3);
    chk("t2_c3_ready", 32'(bus.wb_ready), 32'h1);
    cyc(1'b1, 5'd1, 32'hA4, 1'b0, 5'd0, 32'h0, 5'd0);
    chk("t2_c4_ready", 32'(bus.wb_ready), 32'h0);
    chk_wr("t2_c4", 5'd4, 32'h55);
    cyc(1'b1, 5'd1, 32'hA4, 1'b0, 5'd0, 32'h0, 5'd0);
    chk("t2_c5_ready", 32'(bus.wb_ready), 32'h1);
    chk_wr("t2_c5", 5'd1, 32'hA4);
    idle(5'd0);
    chk("t2_idle_we", 32'(bus.rf_we), 32'h0);

    // Test 3: a main write kills an older pending mul result to the same register.
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h22, 5'd5);
    cyc(1'b1, 5'd5, 32'h33, 1'b0, 5'd0, 32'h0, 5'd5);
    chk_wr("t3_main", 5'd5, 32'h33);
    chk("t3_main_fwd", bus.fw_data, 32'h22);
    idle(5'd5);
    chk("t3_dead_we",  32'(bus.rf_we),  32'h0);
    chk("t3_dead_hit", 32'(bus.fw_hit), 32'h0);
    idle(5'd5);
    chk("t3_empty_we", 32'(bus.rf_we), 32'h0);

    // Test 4: a mul result and a main write to the same register arrive in the same cycle.
    cyc(1'b1, 5'd7, 32'h44, 1'b1, 5'd7, 32'h99, 5'd7);
    chk_wr("t4_same", 5'd7, 32'h44);
    idle(5'd7);
    chk("t4_dead_we",  32'(bus.rf_we),  32'h0);
    chk("t4_dead_hit", 32'(bus.fw_hit), 32'h0);
    idle(5'd7);
    chk("t4_empty_we", 32'(bus.rf_we), 32'h0);

    // Test 5: fill the FIFO, then test enqueue with a same-cycle pop and an overflow drop.
    cyc(1'b1, 5'd1, 32'hB0, 1'b1, 5'd10, 32'hC0, 5'd0);
    cyc(1'b1, 5'd1, 32'hB1, 1'b1, 5'd11, 32'hC1, 5'd0);
    cyc(1'b1, 5'd1, 32'hB2, 1'b1, 5'd12, 32'hC2, 5'd0);
    cyc(1'b1, 5'd1, 32'hB3, 1'b1, 5'd13, 32'hC3, 5'd0);
    chk("t5_fill_full", 32'(bus.mul_full), 32'h0);
    cyc(1'b1, 5'd1, 32'hB4, 1'b1, 5'd14, 32'hC4, 5'd0);
    chk("t5_c4_full",  32'(bus.mul_full), 32'h1);
    chk("t5_c4_ready", 32'(bus.wb_ready), 32'h0);
    chk_wr("t5_c4", 5'd10, 32'hC0);
    cyc(1'b1, 5'd1, 32'hB4, 1'b1, 5'd15, 32'hC5, 5'd0);
    chk("t5_c5_full", 32'(bus.mul_full), 32'h1);
    chk("t5_c5_ovf",  32'(bus.ovf_err),  32'h0);
    chk_wr("t5_c5", 5'd1, 32'hB4);
    cyc(1'b1, 5'd1, 32'hB5, 1'b0, 5'd0, 32'h0, 5'd15);
    chk("t5_c6_ovf", 32'(bus.ovf_err), 32'h1);
    chk("t5_c6_hit", 32'(bus.fw_hit),  32'h0);
    idle(5'd14);
    chk_wr("t5_d11", 5'd11, 32'hC1);
    chk("t5_fw14_hit", 32'(bus.fw_hit), 32'h1);
    chk("t5_fw14_dat", bus.fw_data,     32'hC4);
    idle(5'd0);
    chk_wr("t5_d12", 5'd12, 32'hC2);
    idle(5'd0);
    chk_wr("t5_d13", 5'd13, 32'hC3);
    idle(5'd0);
    chk_wr("t5_d14", 5'd14, 32'hC4);
    idle(5'd0);
    chk("t5_end_we",   32'(bus.rf_we),    32'h0);
    chk("t5_end_full", 32'(bus.mul_full), 32'h0);
    chk("t5_end_ovf",  32'(bus.ovf_err),  32'h1);

    // Test 6: two pending results to one register, then a reset during the drain.
    cyc(1'b1, 5'd1, 32'hD0, 1'b1, 5'd9, 32'h1, 5'd9);
    cyc(1'b1, 5'd1, 32'hD1, 1'b1, 5'd9, 32'h2, 5'd9);
    cyc(1'b1, 5'd2, 32'hD2, 1'b0, 5'd0, 32'h0, 5'd9);
    chk("t6_hit", 32'(bus.fw_hit), 32'h1);
    chk("t6_fwd", bus.fw_data,     32'h2);
    chk_wr("t6_main", 5'd2, 32'hD2);
    idle(5'd9);
    chk_wr("t6_first", 5'd9, 32'h1);
    chk("t6_first_fwd", bus.fw_data, 32'h2);
    reset = 1'b1;
    idle(5'd9);
    chk("t6_rst_we",    32'(bus.rf_we),    32'h0);
    chk("t6_rst_ready", 32'(bus.wb_ready), 32'h1);
    chk("t6_rst_hit",   32'(bus.fw_hit),   32'h0);
    reset = 1'b0;
    idle(5'd9);
    chk("t6_post_we",   32'(bus.rf_we),   32'h0);
    chk("t6_post_hit",  32'(bus.fw_hit),  32'h0);
    chk("t6_post_ovf",  32'(bus.ovf_err), 32'h0);
    idle(5'd9);
    chk("t6_final_we", 32'(bus.rf_we), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_wb_arbiter.md
Name: cpu_wb_arbiter

Overview:
- Sits between the writeback sources and the register bank's single arbitrated write port.
- Merges two producers: the main pipe writeback (ALU/load, stallable) and the multiplier result stream (non-stallable).
- Mul results are buffered in a small FIFO and drained into idle write slots.
- Enforces WAW ordering, prevents mul starvation, and exposes pending mul results to the forwarding unit.

Parameters:
- REG_WIDTH, 32, data width of a register.
- REG_ADDR, 5, register index width (NUM_REGS = 2**REG_ADDR).
- MUL_DEPTH, 4, mul pending FIFO entries (power of two, >= 2).
- STARVE_LIMIT, 3, cycles a valid mul head may wait before main pipe is stalled for it.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- wb_valid  in  1  main pipe write request.
- wb_reg  in  REG_ADDR  main pipe destination.
- wb_data  in  REG_WIDTH  main pipe data.
- wb_ready  out  1  main write accepted this cycle.
- mul_valid  in  1  mul result arriving (cannot be held off).
- mul_reg  in  REG_ADDR  mul destination.
- mul_data  in  REG_WIDTH  mul data.
- mul_full  out  1  FIFO has no free entry; issue logic must not start a new mul.
- rf_we  out  1  register bank write enable.
- rf_reg  out  REG_ADDR  register bank write index.
- rf_data  out  REG_WIDTH  register bank write data.
- fw_reg  in  REG_ADDR  forwarding lookup index.
- fw_hit  out  1  a live pending mul entry targets fw_reg.
- fw_data  out  REG_WIDTH  data of the youngest live matching entry.
- ovf_err  out  1  sticky: mul_valid arrived while FIFO full.

Behaviour:
- Reset (synchronous): FIFO pointers/count = 0, all entry live bits = 0, starve counter = 0, ovf_err = 0.
- Outputs during and after reset: rf_we = 0, fw_hit = 0, mul_full = 0, wb_ready = 1.
- Reset mid-operation discards all pending mul entries without writing them.
- Write port is combinational from the current state and inputs; exactly one write per cycle at most.
- Arbitration each cycle, in priority order:
  - (a) starve = (starve counter >= STARVE_LIMIT) and a live head exists: drive the head to the port, wb_ready = 0.
  - (b) else wb_valid: drive wb_* to the port, wb_ready = 1.
  - (c) else a live head exists: drive the head.
  - (d) else rf_we = 0.
- wb_ready = !starve (independent of wb_valid).
- Dead (killed) head entries are popped without a write and do not consume the slot; at most one pop per cycle, so one dead pop then a live head is drained the following cycle.
- Starve counter:
  - Increments while a live head exists and is not drained.
  - Clears when the head is drained or FIFO is empty; saturates at STARVE_LIMIT.
- Mul enqueue: mul_valid writes an entry (live = 1) at the tail at the clock edge; earliest drain is the next cycle (1-cycle min latency).
- Simultaneous enqueue and pop is allowed; count is unchanged.
- mul_full = (count == MUL_DEPTH), computed from registered count.
- If mul_valid arrives while full and no pop occurs that cycle, the result is dropped and ovf_err is set.
- If a pop occurs the same cycle, the enqueue succeeds.
- WAW rule: main pipe writes are younger than every pending or same-cycle mul result.
  - An accepted main write (wb_valid & wb_ready) clears live on every FIFO entry with a matching reg.
  - A same-cycle mul arrival with the same reg is enqueued dead.
- Two pending mul entries to the same reg are both written in FIFO order, so the younger one wins.
- Forwarding: fw_hit/fw_data are combinational over live entries; the youngest (closest to tail) match wins.
- An entry being drained this cycle still reports a hit.
- Pointers wrap modulo MUL_DEPTH; count runs 0..MUL_DEPTH.

Test Plan:
- Reset, then mul_valid reg=3 data=0x11 alone → next cycle rf_we=1 rf_reg=3 rf_data=0x11; FIFO empty after; fw_hit=0 for reg 3.
- wb_valid every cycle reg=1 data=0xA0.. with a mul to reg 4 enqueued at t0 → mul held for 3 cycles, wb_ready=0 on the 4th cycle, rf_reg=4 written, then main resumes.
- mul reg=5 data=0x22 enqueued, then main write reg=5 data=0x33 before drain → only 0x33 written; dead entry popped with no rf_we; fw_hit(5)=0 after kill.
- Same-cycle mul_valid reg=7 and wb_valid reg=7 data=0x44 → 0x44 written; reg 7 is never written with the mul data.
- Fill MUL_DEPTH=4 entries while main writes continuously → mul_full=1; an extra mul_valid with no pop sets ovf_err and is not written; a pop plus enqueue in the same cycle is accepted with no error.
- Two pending mul entries to reg 9 (0x1, then 0x2) → fw_data=0x2; writes occur in order 0x1 then 0x2; reset asserted mid-drain → rf_we=0 and no further writes.
